cfg_fifo_wr: RTL and testbench

CFG_FIFO_WR -- requirements
Module: cfg_fifo_wr

---
 rtl/cfg_fifo_wr.sv | 104 ++++++++++
 tb/tb_cfg_fifo_wr.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cfg_fifo_wr.sv
// cfg_fifo_wr: copies a set of config words from memory into the config FIFO; define CFG_FIFO_WR_ABORT_EN to add the abort input
module cfg_fifo_wr #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              full,
  output logic              WR,
  output logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic              DC
`ifdef CFG_FIFO_WR_ABORT_EN
  ,
  input  logic              abort
`endif
);
  typedef enum logic [2:0] {IDLE, RD_MEM, LATCH, PUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic mem_rd_q, mem_rd_d, done_q, done_d, dc_q, dc_d, busy_q, busy_d;
  logic abort_i, push;
`ifdef CFG_FIFO_WR_ABORT_EN
  assign abort_i = abort && (state_q != IDLE);
`else
  assign abort_i = 1'b0;
`endif
  // a word leaves only when the FIFO has room and no abort is cancelling the set
  assign push     = (state_q == PUSH) && !full && !abort_i;
  assign WR       = push;
  assign din      = data_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = ptr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign DC       = dc_q;
  // next state, datapath updates, and strobes pre-decoded from the next state so they come out of flops
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (load && num_words != '0) begin
          ptr_d   = base_addr;
          cnt_d   = num_words;
          state_d = RD_MEM;
        end else if (load) begin
          state_d = DONE;
        end
      end
      RD_MEM: state_d = LATCH;
      LATCH: begin
        data_d  = mem_data;
        state_d = PUSH;
      end
      PUSH: begin
        if (push) begin
          ptr_d   = ptr_q + ADDR_W'(1);
          cnt_d   = cnt_q - ADDR_W'(1);
          state_d = (cnt_q == ADDR_W'(1)) ? DONE : RD_MEM;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;
    dc_d     = (state_d == DONE) ? 1'b1 : (state_q == IDLE && load) ? 1'b0 : dc_q;
    mem_rd_d = state_d == RD_MEM;
    done_d   = state_d == DONE;
    busy_d   = state_d != IDLE;
  end
  // state and output registers, cleared asynchronously so a reset mid-set stops everything at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      mem_rd_q <= 1'b0;
      done_q   <= 1'b0;
      dc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      mem_rd_q <= mem_rd_d;
      done_q   <= done_d;
      dc_q     <= dc_d;
      busy_q   <= busy_d;
    end
  end
endmodule

// File: tb/tb_cfg_fifo_wr.sv
// tb_cfg_fifo_wr: directed bench for cfg_fifo_wr with a one-cycle-latency memory model
module tb_cfg_fifo_wr;
  logic        clk = 1'b0;
  logic        reset, load, full;
  logic [7:0]  base_addr, num_words, mem_addr;
  logic [31:0] mem_data, din;
  logic        mem_rd, WR, busy, done, DC;
`ifdef CFG_FIFO_WR_ABORT_EN
  logic        abort;
`endif
  logic [31:0] mem [256];
  int total = 0, bad = 0;
  int cyc = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, collide = 0, done_t = 0;
  logic [7:0]  addr_q[$];
  logic [31:0] din_q[$];
  int          wr_t[$];

  cfg_fifo_wr dut (
    .clk(clk), .reset(reset), .load(load), .base_addr(base_addr), .num_words(num_words),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .full(full),
    .WR(WR), .din(din), .busy(busy), .done(done), .DC(DC)
`ifdef CFG_FIFO_WR_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd) begin
      rd_cnt <= rd_cnt + 1;
      addr_q.push_back(mem_addr);
    end
    if (WR) begin
      wr_cnt <= wr_cnt + 1;
      din_q.push_back(din);
      wr_t.push_back(cyc);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_t   <= cyc;
    end
    if (mem_rd && WR) collide <= collide + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] b, input logic [7:0] n);
    load = 1'b1;
    base_addr = b;
    num_words = n;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int c = 0;
    while (done !== 1'b1 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk(tag, done, 1);
  endtask

  initial begin
    int rb, wb, db, qb, tb0, c;
    reset = 1'b0; load = 1'b0; full = 1'b0; base_addr = '0; num_words = '0;
`ifdef CFG_FIFO_WR_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 32'hD000_0000 + i;
    mem[8'h10] = 32'hAAAA_0001; mem[8'h11] = 32'hBBBB_0002; mem[8'h12] = 32'hCCCC_0003;
    repeat (2) @(negedge clk);
    chk("reset_outs", {mem_rd, WR, done, DC, busy, mem_addr}, 0);
    reset = 1'b1;
    @(negedge clk);
    // basic set of three words
    qb = din_q.size(); db = done_cnt;
    start(8'h10, 8'd3);
    chk("basic_dc_cleared", DC, 0);
    wait_done("basic_done", 20);
    chk("basic_dc", DC, 1);
    chk("basic_wr_cnt", din_q.size() - qb, 3);
    chk("basic_din0", din_q[qb], 32'hAAAA_0001);
    chk("basic_din1", din_q[qb+1], 32'hBBBB_0002);
    chk("basic_din2", din_q[qb+2], 32'hCCCC_0003);
    chk("basic_rate", wr_t[qb+1] - wr_t[qb], 3);
    @(negedge clk);
    chk("basic_done_after_wr", done_t - wr_t[qb+2], 1);
    chk("basic_one_done", done_cnt - db, 1);
    chk("dc_holds", DC, 1);
    // back-pressure on the second word
    qb = din_q.size(); rb = rd_cnt;
    start(8'h10, 8'd3);
    c = 0;
    while (!(mem_rd === 1'b1 && rd_cnt == rb + 1) && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("bp_reach_2nd_rd", mem_rd, 1);
    full = 1'b1;
    wb = wr_cnt;
    repeat (6) @(negedge clk);
    chk("bp_no_wr_while_full", wr_cnt - wb, 0);
    chk("bp_busy", busy, 1);
    full = 1'b0;
    wait_done("bp_done", 20);
    chk("bp_wr_total", din_q.size() - qb, 3);
    chk("bp_din1", din_q[qb+1], 32'hBBBB_0002);
    chk("bp_din2", din_q[qb+2], 32'hCCCC_0003);
    @(negedge clk);
    // zero count
    rb = rd_cnt; wb = wr_cnt;
    start(8'h33, 8'd0);
    wait_done("zero_done", 1);
    chk("zero_dc", DC, 1);
    @(negedge clk);
    chk("zero_no_rd", rd_cnt - rb, 0);
    chk("zero_no_wr", wr_cnt - wb, 0);
    chk("zero_idle", busy, 0);
    // pointer wrap with a second load ignored mid-set
    qb = din_q.size(); rb = addr_q.size();
    start(8'hFE, 8'd3);
    repeat (2) @(negedge clk);
    start(8'h40, 8'd5);
    wait_done("wrap_done", 20);
    chk("wrap_addr0", addr_q[rb], 8'hFE);
    chk("wrap_addr1", addr_q[rb+1], 8'hFF);
    chk("wrap_addr2", addr_q[rb+2], 8'h00);
    chk("wrap_din2", din_q[qb+2], 32'hD000_0000);
    repeat (4) @(negedge clk);
    chk("ignore_rd_cnt", addr_q.size() - rb, 3);
    chk("ignore_idle", busy, 0);
    // reset after the first write
    wb = wr_cnt; db = done_cnt;
    start(8'h10, 8'd3);
    c = 0;
    while (wr_cnt != wb + 1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("rst_first_wr", wr_cnt - wb, 1);
    reset = 1'b0;
    #1;
    chk("rst_outs", {mem_rd, WR, done, DC, busy, mem_addr}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_done", done_cnt - db, 0);
    chk("rst_no_more_wr", wr_cnt - wb, 1);
    qb = din_q.size();
    start(8'h20, 8'd2);
    wait_done("rst_rerun_done", 20);
    chk("rst_rerun_wr", din_q.size() - qb, 2);
    chk("rst_rerun_din1", din_q[qb+1], 32'hD000_0021);
    @(negedge clk);
`ifdef CFG_FIFO_WR_ABORT_EN
    db = done_cnt; wb = wr_cnt;
    full = 1'b1;
    start(8'h10, 8'd3);
    repeat (3) @(negedge clk);
    chk("abort_in_push", {busy, WR}, 2'b10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    full = 1'b0;
    chk("abort_idle", {busy, DC, done}, 0);
    repeat (4) @(negedge clk);
    chk("abort_no_done", done_cnt - db, 0);
    chk("abort_no_wr", wr_cnt - wb, 0);
    chk("abort_dc", DC, 0);
`endif
    chk("no_rd_wr_overlap", collide, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
